image_read_sequencer: RTL and testbench

Sequencer that drains one received 784-element image out of the UART data collector's read port and streams it to a downstream consumer (inference engine) over a valid/ready handshake. Sits between the collector's address/element read interface and the compute datapath. Owns the collector's read-address bus, produces per-element index and last markers, and reports start/busy/done/error status to the top-level control.

---
 rtl/image_read_sequencer.sv | 159 +++++++++++++++
 tb/tb_image_read_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_read_sequencer.sv
// Streams one N_ELEMS-element image from the collector read port to a valid/ready consumer.
// Optional nonzero-element counter is built only when SEQ_ONES_COUNT_EN is defined.
module image_read_sequencer #(
    parameter int N_ELEMS = 784
) (
    input  logic               i_Clock,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic               i_Abort,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Error,
    input  logic               i_Data_Valid,
    output logic [9:0]         o_Data_Addr,
    input  logic signed [31:0] i_Data_Element,
    output logic               o_Elem_Valid,
    input  logic               i_Elem_Ready,
    output logic signed [31:0] o_Elem_Data,
    output logic [9:0]         o_Elem_Index,
    output logic               o_Elem_Last,
    output logic [9:0]         o_Ones_Count
);

    // state     | meaning
    // S_IDLE    | waiting for i_Start, read address parked at 0
    // S_WAIT    | started, waiting for the collector image to become valid
    // S_STREAM  | issuing reads and handing elements to the consumer
    // S_DONE    | last element accepted, o_Done pulses for this cycle
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DONE} state_t;

    localparam logic [10:0] N_CNT     = 11'(N_ELEMS);
    localparam logic [9:0]  LAST_ADDR = 10'(N_ELEMS - 1);

    state_t             state_q, state_d;
    logic [9:0]         addr_q, addr_d;
    logic [10:0]        issued_q, issued_d;
    logic               valid_q, valid_d;
    logic signed [31:0] data_q, data_d;
    logic [9:0]         index_q, index_d;
    logic               last_q, last_d;
    logic               error_q, error_d;
    logic               start_ok;
    logic               accept;
    logic               load;

    assign accept = valid_q && i_Elem_Ready;
    assign load   = (!valid_q || i_Elem_Ready) && (issued_q < N_CNT);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            issued_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            index_q  <= index_d;
            last_q   <= last_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        valid_d  = valid_q;
        data_d   = data_q;
        index_d  = index_q;
        last_d   = last_q;
        error_d  = 1'b0;
        start_ok = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    state_d  = S_WAIT;
                    start_ok = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_Data_Valid) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (!i_Data_Valid) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    valid_d = 1'b0;
                end else if (load) begin
                    data_d   = i_Data_Element;
                    index_d  = addr_q;
                    valid_d  = 1'b1;
                    last_d   = (addr_q == LAST_ADDR);
                    issued_d = issued_q + 11'd1;
                    if (addr_q != LAST_ADDR) addr_d = addr_q + 10'd1;
                end else if (accept) begin
                    // Only reachable once every element is issued, so this is the last one.
                    valid_d = 1'b0;
                    if (last_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_Abort) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            error_d  = 1'b0;
            start_ok = 1'b0;
        end

        if (state_d != S_STREAM) begin
            addr_d   = '0;
            issued_d = '0;
        end
    end

`ifdef SEQ_ONES_COUNT_EN
    logic [9:0] ones_q, ones_d;

    always_comb begin
        ones_d = ones_q;
        if (start_ok)
            ones_d = '0;
        else if (accept && (data_q != 32'sd0))
            ones_d = ones_q + 10'd1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) ones_q <= '0;
        else          ones_q <= ones_d;
    end

    assign o_Ones_Count = ones_q;
`else
    assign o_Ones_Count = '0;
`endif

    assign o_Busy       = (state_q != S_IDLE);
    assign o_Done       = (state_q == S_DONE);
    assign o_Error      = error_q;
    assign o_Data_Addr  = addr_q;
    assign o_Elem_Valid = valid_q;
    assign o_Elem_Data  = data_q;
    assign o_Elem_Index = index_q;
    assign o_Elem_Last  = last_q;

endmodule

// File: tb/tb_image_read_sequencer.sv
// Self-checking bench for image_read_sequencer: handshake-level reference model driven by
// random images and random/toggling consumer ready.
module tb_image_read_sequencer;
    localparam int N = 784;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               dvalid = 1'b0;
    logic               ready = 1'b0;
    logic               busy, done, err, evalid, elast;
    logic [9:0]         addr, eidx, ones;
    logic signed [31:0] edata, din;

    logic signed [31:0] img [N];

    int n_chk = 0;
    int n_fail = 0;
    int e, exp_idx, exp_ones, done_edge, last_acc_edge;
    bit prev_valid;

    assign din = img[addr];

    always #5 clk = ~clk;

    image_read_sequencer #(.N_ELEMS(N)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Abort(abort),
        .o_Busy(busy), .o_Done(done), .o_Error(err),
        .i_Data_Valid(dvalid), .o_Data_Addr(addr), .i_Data_Element(din),
        .o_Elem_Valid(evalid), .i_Elem_Ready(ready), .o_Elem_Data(edata),
        .o_Elem_Index(eidx), .o_Elem_Last(elast), .o_Ones_Count(ones)
    );

    function automatic int exp_ones_out(input int cnt);
`ifdef SEQ_ONES_COUNT_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        exp_idx = 0;
        exp_ones = 0;
        done_edge = -1;
        last_acc_edge = -1;
        prev_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggling, 2: random ready
    task automatic run_stream(input int first_edge, input int mode, input int stop_idx,
                              input bit mid_start, output bit stopped);
        bit r;
        bit exp_v;
        bit exp_busy;
        bit pulsed = 1'b0;
        bit finished = 1'b0;
        stopped = 1'b0;
        while (!finished && !stopped) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((e + 1) % 2 == 1);
                default: r = ($urandom_range(3) != 0);
            endcase
            ready = r;
            if (mid_start && !pulsed && exp_idx == 200) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            tick();
            start = 1'b0;
            if (prev_valid && r) begin
                if (img[exp_idx] != 0) exp_ones++;
                if (exp_idx == N - 1) last_acc_edge = e;
                exp_idx++;
            end
            exp_v = (e >= first_edge) && (exp_idx < N);
            prev_valid = exp_v;
            n_chk++;
            if (evalid !== exp_v) begin
                n_fail++;
                $display("FAIL elem_valid edge %0d: got %b expected %b", e, evalid, exp_v);
            end
            if (exp_v) begin
                n_chk++;
                if (eidx !== 10'(exp_idx)) begin
                    n_fail++;
                    $display("FAIL elem_index edge %0d: got %0d expected %0d", e, eidx, exp_idx);
                end
                n_chk++;
                if (edata !== img[exp_idx]) begin
                    n_fail++;
                    $display("FAIL elem_data idx %0d: got %0d expected %0d", exp_idx, edata, img[exp_idx]);
                end
                n_chk++;
                if (elast !== (exp_idx == N - 1)) begin
                    n_fail++;
                    $display("FAIL elem_last idx %0d: got %b expected %b", exp_idx, elast, exp_idx == N - 1);
                end
            end
            n_chk++;
            if (done !== (last_acc_edge == e)) begin
                n_fail++;
                $display("FAIL done edge %0d: got %b expected %b", e, done, last_acc_edge == e);
            end
            if (done === 1'b1) done_edge = e;
            exp_busy = !(last_acc_edge >= 0 && e > last_acc_edge);
            n_chk++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy edge %0d: got %b expected %b", e, busy, exp_busy);
            end
            if (last_acc_edge >= 0 && e > last_acc_edge) finished = 1'b1;
            if (stop_idx >= 0 && exp_idx == stop_idx && exp_v) stopped = 1'b1;
            if (e > 4000) begin
                n_fail++;
                $display("FAIL stream_timeout: got edge %0d expected completion by 4000", e);
                finished = 1'b1;
            end
        end
        if (finished) begin
            n_chk++;
            if (ones !== 10'(exp_ones_out(exp_ones))) begin
                n_fail++;
                $display("FAIL ones_count: got %0d expected %0d", ones, exp_ones_out(exp_ones));
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            img[k] = ($urandom_range(2) == 0) ? 32'sd0 : $signed($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        n_chk++;
        if ({busy, done, err, evalid, elast} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s flags: got %b expected 00000", tag, {busy, done, err, evalid, elast});
        end
        n_chk++;
        if ({addr, eidx, ones} !== 30'b0 || edata !== 32'sd0) begin
            n_fail++;
            $display("FAIL %s values: got addr %0d idx %0d ones %0d data %0d expected all 0",
                     tag, addr, eidx, ones, edata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_alternating();
        bit s;
        for (int k = 0; k < N; k++) img[k] = (k % 2 == 0) ? 32'sd1 : 32'sd0;
        dvalid = 1'b1;
        do_start();
        run_stream(2, 0, -1, 1'b0, s);
        n_chk++;
        if (done_edge !== 786) begin
            n_fail++;
            $display("FAIL alt_done_edge: got %0d expected 786", done_edge);
        end
        n_chk++;
        if (ones !== 10'(exp_ones_out(392))) begin
            n_fail++;
            $display("FAIL alt_ones: got %0d expected %0d", ones, exp_ones_out(392));
        end
    endtask

    task automatic test_ready_toggle();
        bit s;
        fill_random();
        dvalid = 1'b1;
        do_start();
        run_stream(2, 1, -1, 1'b0, s);
        n_chk++;
        if (done_edge !== 786 + 783) begin
            n_fail++;
            $display("FAIL toggle_done_edge: got %0d expected %0d", done_edge, 786 + 783);
        end
    endtask

    task automatic test_random_ready();
        bit s;
        fill_random();
        dvalid = 1'b1;
        do_start();
        run_stream(2, 2, -1, 1'b0, s);
    endtask

    task automatic test_wait_data();
        bit s;
        fill_random();
        dvalid = 1'b0;
        ready = 1'b1;
        do_start();
        for (int c = 0; c < 50; c++) begin
            tick();
            n_chk++;
            if (busy !== 1'b1 || evalid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_data edge %0d: got busy %b valid %b expected busy 1 valid 0", e, busy, evalid);
            end
        end
        dvalid = 1'b1;
        run_stream(52, 0, -1, 1'b0, s);
    endtask

    task automatic test_abort();
        bit s;
        int ones_before;
        fill_random();
        dvalid = 1'b1;
        do_start();
        run_stream(2, 0, 300, 1'b0, s);
        ones_before = exp_ones;
        ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (evalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got valid %b busy %b done %b expected 0 0 0", evalid, busy, done);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got done %b busy %b expected 0 0", done, busy);
        end
        n_chk++;
        if (ones !== 10'(exp_ones_out(ones_before))) begin
            n_fail++;
            $display("FAIL abort_ones_hold: got %0d expected %0d", ones, exp_ones_out(ones_before));
        end
        do_start();
        run_stream(2, 0, 5, 1'b0, s);
        abort = 1'b1;
        ready = 1'b0;
        tick();
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_restart_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_data_invalid();
        bit s;
        fill_random();
        dvalid = 1'b1;
        do_start();
        run_stream(2, 2, 500, 1'b1, s);
        ready = 1'b0;
        dvalid = 1'b0;
        tick();
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0 || evalid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL data_drop: got err %b busy %b valid %b done %b expected 1 0 0 0",
                     err, busy, evalid, done);
        end
        dvalid = 1'b1;
        tick();
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL error_pulse_width: got err %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid_stream();
        bit s;
        fill_random();
        dvalid = 1'b1;
        do_start();
        run_stream(2, 0, 100, 1'b0, s);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_stream");
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        tick();
        n_chk++;
        if (busy !== 1'b0 || evalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_release: got busy %b valid %b expected 0 0", busy, evalid);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) img[k] = 32'sd0;
        e = 0;
        test_reset();
        test_alternating();
        test_ready_toggle();
        test_random_ready();
        test_wait_data();
        test_abort();
        test_data_invalid();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
